ntt_stage_sched: RTL and testbench

- Sequences one full Kyber-size (N=256, 12-bit) NTT or iNTT over 8 dual-port coefficient banks of 32 words each, with eight butterfly units (BUs) in parallel.
- Drives the bank-select/routing stage with len and mode.
- Generates bank read addresses, twiddle base index and delayed write-back addresses for all 7 layers.
- Reports busy/done to the top-level controller.

---
 rtl/ntt_stage_sched_pkg.sv | 38 +++
 rtl/ntt_stage_sched_if.sv | 41 ++++
 rtl/ntt_stage_sched_delay_line.sv | 37 +++
 rtl/ntt_stage_sched.sv | 147 ++++++++++++++
 tb/tb_ntt_stage_sched.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_stage_sched_pkg.sv
// ============================================================================
// Module : ntt_ctrl_pkg
// Brief  : Shared types and constants for the NTT stage scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int N              = 256;
    localparam int NUM_BANKS      = 8;
    localparam int WORDS_PER_BANK = N / NUM_BANKS;
    localparam int CYC_PER_STAGE  = N / (2 * NUM_BANKS);
    localparam int NUM_STAGES     = 7;

    localparam logic [7:0] LEN_NTT_FIRST  = 8'd128;
    localparam logic [7:0] LEN_INTT_FIRST = 8'd2;

    // len is always a power of two, so its log2 is the index of the set bit
    function automatic logic [2:0] log2_pow2(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_stage_sched_if.sv
// ============================================================================
// Module : ntt_stage_sched_if
// Brief  : Controller/bank-side signal bundle of the NTT stage scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ntt_stage_sched_if #(
    parameter int ADDR_W = 5
) ();
    logic              start_i;
    logic              mode_i;
    logic              busy_o;
    logic              done_o;
    logic              intt_o;
    logic [2:0]        stage_o;
    logic [7:0]        len_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_a_o;
    logic [ADDR_W-1:0] rd_addr_b_o;
    logic [6:0]        zeta_idx_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_a_o;
    logic [ADDR_W-1:0] wr_addr_b_o;

    modport master (
        output start_i, mode_i,
        input  busy_o, done_o, intt_o, stage_o, len_o,
        input  rd_en_o, rd_addr_a_o, rd_addr_b_o, zeta_idx_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o
    );

    modport slave (
        input  start_i, mode_i,
        output busy_o, done_o, intt_o, stage_o, len_o,
        output rd_en_o, rd_addr_a_o, rd_addr_b_o, zeta_idx_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
endinterface

`default_nettype wire

// File: rtl/ntt_stage_sched_delay_line.sv
// ============================================================================
// Module : ntt_delay_line
// Brief  : Fixed-depth shift register carrying read strobes to the write side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
    logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/ntt_stage_sched.sv
// ============================================================================
// Module : ntt_stage_sched
// Brief  : Layer/address/twiddle sequencer for an 8-lane N=256 NTT/iNTT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_stage_sched
    import ntt_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int BU_LAT = 4,
    parameter int ADDR_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ntt_stage_sched_if.slave bus
);
    localparam int D  = RD_LAT + BU_LAT;
    localparam int DW = 1 + 2 * ADDR_W;

    state_e      state_q, state_d;
    logic        mode_q,  mode_d;
    logic [2:0]  stage_q, stage_d;
    logic [7:0]  len_q,   len_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [3:0]  dcnt_q,  dcnt_d;

    logic              rd_en_w;
    logic [ADDR_W-1:0] rd_addr_a_w;
    logic [ADDR_W-1:0] rd_addr_b_w;
    logic [6:0]        zeta_w;
    logic [DW-1:0]     wb_w;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            stage_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            stage_q <= stage_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        stage_d = stage_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_READ;
                    mode_d  = bus.mode_i;
                    stage_d = '0;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    len_d   = bus.mode_i ? LEN_INTT_FIRST : LEN_NTT_FIRST;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(CYC_PER_STAGE - 1)) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q + 4'd1;
                // Next layer starts only once the last write of this one has landed
                if (dcnt_q == 4'(D - 1)) begin
                    cnt_d = '0;
                    if (stage_q == 3'(NUM_STAGES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        stage_d = stage_q + 3'd1;
                        len_d   = mode_q ? (len_q << 1) : (len_q >> 1);
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        logic [2:0] lg;
        logic [6:0] grp;
        logic [4:0] stride;
        logic [3:0] mask;
        logic [4:0] a5;
        logic [4:0] b5;
        lg     = log2_pow2(len_q);
        // Butterfly-group index of lane 0: jstart/(2*len) == 8*cnt/len for every len
        grp    = {cnt_q, 3'b000} >> lg;
        stride = 5'(len_q >> 3);
        mask   = 4'(stride - 5'd1);
        if (len_q >= 8'd8) begin
            a5 = {1'b0, cnt_q} + {1'b0, cnt_q & ~mask};
            b5 = a5 + stride;
        end else begin
            a5 = {cnt_q, 1'b0};
            b5 = {cnt_q, 1'b1};
        end
        rd_en_w     = (state_q == ST_READ);
        rd_addr_a_w = rd_en_w ? ADDR_W'(a5) : '0;
        rd_addr_b_w = rd_en_w ? ADDR_W'(b5) : '0;
        if (!rd_en_w)    zeta_w = '0;
        else if (mode_q) zeta_w = 7'((9'd256 >> lg) - 9'd1) - grp;
        else             zeta_w = 7'(8'd128 >> lg) + grp;
    end

    ntt_delay_line #(
        .DEPTH (D),
        .WIDTH (DW)
    ) u_wb_delay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  ({rd_en_w, rd_addr_a_w, rd_addr_b_w}),
        .dout_o (wb_w)
    );

    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.done_o      = (state_q == ST_DONE);
    assign bus.intt_o      = mode_q;
    assign bus.stage_o     = stage_q;
    assign bus.len_o       = len_q;
    assign bus.rd_en_o     = rd_en_w;
    assign bus.rd_addr_a_o = rd_addr_a_w;
    assign bus.rd_addr_b_o = rd_addr_b_w;
    assign bus.zeta_idx_o  = zeta_w;
    assign {bus.wr_en_o, bus.wr_addr_a_o, bus.wr_addr_b_o} = wb_w;

endmodule

`default_nettype wire

// File: tb/tb_ntt_stage_sched.sv
// ============================================================================
// Module : tb_ntt_stage_sched
// Brief  : Directed self-checking bench for ntt_stage_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ntt_stage_sched;

    localparam int HMAX = 320;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ntt_stage_sched_if #(.ADDR_W(5)) bus ();

    ntt_stage_sched #(
        .RD_LAT (1),
        .BU_LAT (4),
        .ADDR_W (5)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic       rd_h   [HMAX];
    logic [4:0] ra_h   [HMAX];
    logic [4:0] rb_h   [HMAX];
    logic [6:0] z_h    [HMAX];
    logic       wr_h   [HMAX];
    logic [4:0] wa_h   [HMAX];
    logic [4:0] wb_h   [HMAX];
    logic       busy_h [HMAX];
    logic       done_h [HMAX];
    logic       intt_h [HMAX];
    logic [2:0] stg_h  [HMAX];
    logic [7:0] len_h  [HMAX];

    function automatic logic [42:0] all_outs();
        return {bus.busy_o, bus.done_o, bus.intt_o, bus.stage_o, bus.len_o,
                bus.rd_en_o, bus.rd_addr_a_o, bus.rd_addr_b_o, bus.zeta_idx_o,
                bus.wr_en_o, bus.wr_addr_a_o, bus.wr_addr_b_o};
    endfunction

    task automatic sample(input int c);
        rd_h[c]   = bus.rd_en_o;   ra_h[c]  = bus.rd_addr_a_o; rb_h[c] = bus.rd_addr_b_o;
        z_h[c]    = bus.zeta_idx_o;
        wr_h[c]   = bus.wr_en_o;   wa_h[c]  = bus.wr_addr_a_o; wb_h[c] = bus.wr_addr_b_o;
        busy_h[c] = bus.busy_o;    done_h[c] = bus.done_o;     intt_h[c] = bus.intt_o;
        stg_h[c]  = bus.stage_o;   len_h[c] = bus.len_o;
    endtask

    // Cycle c is the clock period following the (c-1)-th edge after start sampling
    task automatic run(input logic m, input bit hold, input bit restart, input int ncyc);
        bus.mode_i  = m;
        bus.start_i = 1'b1;
        sample(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            sample(c);
            bus.start_i = (hold && c <= 148) || (restart && c == 149);
        end
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
        #2;
        checks++;
        if (all_outs() !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (all_outs() !== 43'd0) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_ntt();
        int c_at [5] = '{1, 16, 66, 130, 139};
        int a_ex [5] = '{0, 15, 4, 6, 24};
        int b_ex [5] = '{16, 31, 6, 7, 25};
        int z_ex [5] = '{1, 1, 9, 76, 112};
        int nrd, nwr, ndone, first_done, bad_mode;
        run(1'b0, 1'b0, 1'b0, 155);

        checks++;
        if (busy_h[0] !== 1'b0 || busy_h[1] !== 1'b1) begin
            failures++;
            $display("FAIL ntt_busy_rise got c0=%b c1=%b exp c0=0 c1=1", busy_h[0], busy_h[1]);
        end
        nrd = 0; nwr = 0; ndone = 0; first_done = -1; bad_mode = 0;
        for (int c = 1; c <= 155; c++) begin
            nrd += int'(rd_h[c]);
            nwr += int'(wr_h[c]);
            if (done_h[c]) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (busy_h[c] && intt_h[c] !== 1'b0) bad_mode++;
        end
        checks++;
        if (first_done !== 148 || ndone !== 1) begin
            failures++;
            $display("FAIL ntt_done got cycle=%0d count=%0d exp cycle=148 count=1", first_done, ndone);
        end
        checks++;
        if (busy_h[148] !== 1'b1 || busy_h[149] !== 1'b0) begin
            failures++;
            $display("FAIL ntt_busy_fall got c148=%b c149=%b exp 1/0", busy_h[148], busy_h[149]);
        end
        checks++;
        if (nrd !== 112 || nwr !== 112) begin
            failures++;
            $display("FAIL ntt_pulse_count got rd=%0d wr=%0d exp 112/112", nrd, nwr);
        end
        checks++;
        if (bad_mode !== 0) begin
            failures++;
            $display("FAIL ntt_intt_o got %0d cycles with intt_o=1 exp 0", bad_mode);
        end
        for (int k = 0; k < 7; k++) begin
            logic [7:0] el;
            el = 8'd128 >> k;
            checks++;
            if (len_h[1+21*k] !== el || len_h[21+21*k] !== el || stg_h[1+21*k] !== 3'(k)) begin
                failures++;
                $display("FAIL ntt_layer k=%0d got len=%0d/%0d stage=%0d exp len=%0d stage=%0d",
                         k, len_h[1+21*k], len_h[21+21*k], stg_h[1+21*k], el, k);
            end
        end
        for (int i = 0; i < 5; i++) begin
            int c;
            c = c_at[i];
            checks++;
            if (rd_h[c] !== 1'b1 || int'(ra_h[c]) !== a_ex[i] || int'(rb_h[c]) !== b_ex[i]
                || int'(z_h[c]) !== z_ex[i]) begin
                failures++;
                $display("FAIL ntt_addr cycle=%0d got rd=%b a=%0d b=%0d z=%0d exp rd=1 a=%0d b=%0d z=%0d",
                         c, rd_h[c], ra_h[c], rb_h[c], z_h[c], a_ex[i], b_ex[i], z_ex[i]);
            end
        end
    endtask

    task automatic test_intt();
        int c_at [5] = '{1, 27, 90, 127, 142};
        int a_ex [5] = '{0, 10, 9, 0, 15};
        int b_ex [5] = '{1, 11, 13, 16, 31};
        int z_ex [5] = '{127, 53, 6, 1, 1};
        int bad_mode, ndone;
        run(1'b1, 1'b0, 1'b0, 155);
        bad_mode = 0; ndone = 0;
        for (int c = 1; c <= 148; c++) begin
            if (intt_h[c] !== 1'b1 || busy_h[c] !== 1'b1) bad_mode++;
            ndone += int'(done_h[c]);
        end
        checks++;
        if (bad_mode !== 0 || ndone !== 1 || done_h[148] !== 1'b1) begin
            failures++;
            $display("FAIL intt_run got bad_cycles=%0d dones=%0d done148=%b exp 0/1/1",
                     bad_mode, ndone, done_h[148]);
        end
        for (int k = 0; k < 7; k++) begin
            logic [7:0] el;
            el = 8'd2 << k;
            checks++;
            if (len_h[1+21*k] !== el || len_h[21+21*k] !== el) begin
                failures++;
                $display("FAIL intt_len k=%0d got %0d/%0d exp %0d", k, len_h[1+21*k], len_h[21+21*k], el);
            end
        end
        for (int i = 0; i < 5; i++) begin
            int c;
            c = c_at[i];
            checks++;
            if (rd_h[c] !== 1'b1 || int'(ra_h[c]) !== a_ex[i] || int'(rb_h[c]) !== b_ex[i]
                || int'(z_h[c]) !== z_ex[i]) begin
                failures++;
                $display("FAIL intt_addr cycle=%0d got rd=%b a=%0d b=%0d z=%0d exp rd=1 a=%0d b=%0d z=%0d",
                         c, rd_h[c], ra_h[c], rb_h[c], z_h[c], a_ex[i], b_ex[i], z_ex[i]);
            end
        end
    endtask

    task automatic test_write_alignment();
        int bad_align, bad_rd, bad_gap;
        run(1'b0, 1'b0, 1'b0, 155);
        bad_align = 0; bad_rd = 0; bad_gap = 0;
        for (int c = 6; c <= 155; c++) begin
            if ({wr_h[c], wa_h[c], wb_h[c]} !== {rd_h[c-5], ra_h[c-5], rb_h[c-5]}) bad_align++;
        end
        for (int c = 1; c <= 155; c++) begin
            logic exp_rd;
            exp_rd = (c <= 147) && (((c - 1) % 21) < 16);
            if (rd_h[c] !== exp_rd) bad_rd++;
        end
        for (int k = 0; k < 6; k++) begin
            if (wr_h[21+21*k] !== 1'b1 || wr_h[22+21*k] !== 1'b0 || rd_h[22+21*k] !== 1'b1) bad_gap++;
        end
        checks++;
        if (bad_align !== 0) begin
            failures++;
            $display("FAIL wr_align got %0d misaligned cycles exp 0", bad_align);
        end
        checks++;
        if (bad_rd !== 0) begin
            failures++;
            $display("FAIL rd_schedule got %0d wrong rd_en cycles exp 0", bad_rd);
        end
        checks++;
        if (bad_gap !== 0) begin
            failures++;
            $display("FAIL layer_hazard got %0d bad layer boundaries exp 0", bad_gap);
        end
    endtask

    task automatic test_start_ignore();
        int ndone1, ndone2;
        run(1'b0, 1'b1, 1'b1, 300);
        ndone1 = 0; ndone2 = 0;
        for (int c = 1; c <= 149; c++) ndone1 += int'(done_h[c]);
        for (int c = 150; c <= 300; c++) ndone2 += int'(done_h[c]);
        checks++;
        if (ndone1 !== 1 || done_h[148] !== 1'b1 || busy_h[149] !== 1'b0) begin
            failures++;
            $display("FAIL start_held got dones=%0d done148=%b busy149=%b exp 1/1/0",
                     ndone1, done_h[148], busy_h[149]);
        end
        checks++;
        if (busy_h[150] !== 1'b1 || done_h[297] !== 1'b1 || ndone2 !== 1 || busy_h[298] !== 1'b0) begin
            failures++;
            $display("FAIL restart got busy150=%b done297=%b dones=%0d busy298=%b exp 1/1/1/0",
                     busy_h[150], done_h[297], ndone2, busy_h[298]);
        end
    endtask

    task automatic test_reset_mid_run();
        int nwr, nrd, nbusy;
        run(1'b0, 1'b0, 1'b0, 60);
        checks++;
        if (wr_h[60] !== 1'b1 || busy_h[60] !== 1'b1) begin
            failures++;
            $display("FAIL midrun_active got wr=%b busy=%b exp 1/1", wr_h[60], busy_h[60]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 43'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", all_outs());
        end
        @(posedge clk); #2 rst_n = 1'b1;
        nwr = 0; nrd = 0; nbusy = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            nwr   += int'(bus.wr_en_o);
            nrd   += int'(bus.rd_en_o);
            nbusy += int'(bus.busy_o);
        end
        checks++;
        if (nwr !== 0 || nrd !== 0 || nbusy !== 0) begin
            failures++;
            $display("FAIL post_reset got wr=%0d rd=%0d busy=%0d exp 0/0/0", nwr, nrd, nbusy);
        end
    endtask

    initial begin
        test_reset();
        test_ntt();
        test_intt();
        test_write_alignment();
        test_start_ignore();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
